vga_rx_capture: RTL and testbench
=================================

Name: vga_rx_capture

Overview:
- Receive-side counterpart of the team's VGA timing generator. Samples Hs, Vs, D_En and rgb on the 25 MHz pixel clock.
- Recovers pixel coordinates, measures line and frame timing, and declares lock once the format is stable.
- Emits a per-pixel write strobe with x/y for a downstream frame buffer or checker.
- Sits at the far end of the VGA link: loopback test path or capture front end.

Parameters:
- DATA_WIDTH, 8, width of rgb_in / pix_data
- CNT_WIDTH, 10, width of coordinate and measurement counters
- H_ACTIVE, 640, expected active pixels per line
- V_ACTIVE, 480, expected active lines per frame
- LOCK_FRAMES, 2, consecutive good frames required for lock (1..7)

Ports:
- clk  in  1  pixel clock (clk_25 domain)
- rst  in  1  synchronous reset, active-high
- en  in  1  capture enable; when low, state holds and pix_valid=0
- Hs  in  1  horizontal sync, active-low pulse
- Vs  in  1  vertical sync, active-low pulse
- D_En  in  1  data enable, high during active video
- rgb_in  in  DATA_WIDTH  pixel data, valid when D_En=1
- pix_valid  out  1  captured pixel strobe
- pix_data  out  DATA_WIDTH  captured pixel
- pix_x  out  CNT_WIDTH  column of pix_data, 0-based
- pix_y  out  CNT_WIDTH  row of pix_data, 0-based
- sof  out  1  one-cycle pulse on Vs falling edge
- eol  out  1  one-cycle pulse on D_En falling edge
- locked  out  1  format locked
- err_fmt  out  1  one-cycle pulse on format violation
- line_len  out  CNT_WIDTH  clk cycles between the last two Hs falling edges
- frame_lines  out  CNT_WIDTH  Hs falling edges between the last two Vs falling edges

Behaviour:
- Reset: all outputs 0; state SEARCH; all counters and edge registers 0. Previous-sample registers reset to Hs=1, Vs=1, D_En=0, so no false edge occurs on the first cycle after reset.
- Input stage: Hs, Vs, D_En and rgb_in registered once. Edges are detected against a second register stage.
- Latency: pix_valid/pix_data appear exactly 2 clk after the input cycle. sof and eol use the same 2-clk alignment.
- Counters:
  - h_len counts clk; cleared to 1 on Hs fall, when the previous value is latched into line_len. Saturates at all-ones.
  - line count clears on Vs fall, when the previous value is latched into frame_lines; increments on Hs fall.
  - x clears on Hs fall and increments per D_En=1 sample.
  - y clears on Vs fall and increments on D_En fall.
- Simultaneous Hs fall and Vs fall: both clears apply; line count becomes 1.
- FSM:
  - SEARCH: wait for Vs fall -> MEASURE with good_cnt=0.
  - MEASURE: at each Vs fall, check the frame just ended. Good frame = every line had x==H_ACTIVE at D_En fall, and y==V_ACTIVE. Good: good_cnt++; when good_cnt reaches LOCK_FRAMES -> LOCKED. Bad: good_cnt=0, stay in MEASURE.
  - LOCKED: locked=1. Any per-line x!=H_ACTIVE at D_En fall, y>V_ACTIVE, or a bad frame at Vs fall -> err_fmt pulse, locked=0 the next cycle, go to MEASURE.
- pix_valid = 1 only when locked, en=1, registered D_En=1, x<H_ACTIVE and y<V_ACTIVE. Out-of-range pixels are dropped silently; the error is raised at line or frame end.
- en low: counters, FSM and measurements freeze; edges occurring while en=0 are lost. On re-enable the FSM returns to SEARCH.
- rst mid-frame: returns to SEARCH; lock requires LOCK_FRAMES+1 Vs falls.

Optional Feature:
- Macro RX_FRAME_CHECKSUM_EN.
- Defined: extra output frame_sum (16 bits) = modulo-2^16 sum of every pix_data with pix_valid=1 since the previous sof. Latched one cycle after sof; the accumulator clears on sof. Reset value 0.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- 800-clk lines, Hs low 96 clk, 640 D_En clk per line, 525 lines, Vs low 2 lines, 480 active lines -> line_len=800, frame_lines=525, locked rises in the cycle after the 3rd Vs fall following reset, no err_fmt.
- Locked, rgb_in=x^y pattern -> pix_valid exactly 640*480 times per frame; each pix_data equals pix_x^pix_y at 2-clk latency; sof once per frame, eol 480 times.
- Locked, one line carries 641 D_En pixels -> pixel 641 is not strobed; err_fmt pulses at that line's D_En fall; locked=0; relock after 2 good frames.
- rst asserted at line 200 for 1 clk -> all outputs 0 next cycle; locked stays 0 until the 3rd Vs fall after reset.
- en low for 1000 clk mid-frame -> no pix_valid; FSM returns to SEARCH; relock after the 3rd subsequent Vs fall.
- RX_FRAME_CHECKSUM_EN defined, constant rgb_in=8'h01 -> frame_sum=307200 mod 65536 = 0xB000 after each sof.

Source files
------------

// File: rtl/vga_rx_capture.sv
// VGA receive front end: recovers pixel coordinates, measures line/frame timing and locks onto a stable format.
// Optional RX_FRAME_CHECKSUM_EN adds a 16-bit per-frame pixel checksum output (frame_sum).
module vga_rx_capture #(
    parameter int DATA_WIDTH  = 8,
    parameter int CNT_WIDTH   = 10,
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int LOCK_FRAMES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  Hs,
    input  logic                  Vs,
    input  logic                  D_En,
    input  logic [DATA_WIDTH-1:0] rgb_in,
    output logic                  pix_valid,
    output logic [DATA_WIDTH-1:0] pix_data,
    output logic [CNT_WIDTH-1:0]  pix_x,
    output logic [CNT_WIDTH-1:0]  pix_y,
    output logic                  sof,
    output logic                  eol,
    output logic                  locked,
    output logic                  err_fmt,
    output logic [CNT_WIDTH-1:0]  line_len,
    output logic [CNT_WIDTH-1:0]  frame_lines
`ifdef RX_FRAME_CHECKSUM_EN
    ,
    output logic [15:0]           frame_sum
`endif
);

    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

    localparam logic [CNT_WIDTH-1:0] H_ACT  = CNT_WIDTH'(H_ACTIVE);
    localparam logic [CNT_WIDTH-1:0] V_ACT  = CNT_WIDTH'(V_ACTIVE);
    localparam logic [2:0]           LOCK_N = 3'(LOCK_FRAMES);

    state_t state_reg, state_next;
    logic [2:0] good_cnt_reg, good_next;
    logic       err_next;

    logic hs_s1_reg, vs_s1_reg, de_s1_reg;
    logic hs_s2_reg, vs_s2_reg, de_s2_reg;
    logic [DATA_WIDTH-1:0] rgb_s1_reg;
    logic en_d_reg;

    logic [CNT_WIDTH-1:0] h_len_reg, line_cnt_reg, x_reg, y_reg;
    logic                 line_bad_reg;

    logic hs_fall, vs_fall, de_fall, frame_ok, line_err, capture;

    assign hs_fall  = hs_s2_reg & ~hs_s1_reg;
    assign vs_fall  = vs_s2_reg & ~vs_s1_reg;
    assign de_fall  = de_s2_reg & ~de_s1_reg;
    assign frame_ok = ~line_bad_reg && (y_reg == V_ACT);
    // y_reg >= V_ACT here means this D_En fall ends a line beyond the active height
    assign line_err = de_fall && ((x_reg != H_ACT) || (y_reg >= V_ACT));
    assign capture  = en && en_d_reg && (state_reg == LOCKED) && de_s1_reg
                      && (x_reg < H_ACT) && (y_reg < V_ACT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= SEARCH;
            good_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            good_cnt_reg <= good_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        good_next  = good_cnt_reg;
        err_next   = 1'b0;
        if (en) begin
            if (!en_d_reg) begin
                // leaving a paused period: timing may have drifted, start over
                state_next = SEARCH;
                good_next  = '0;
            end else begin
                case (state_reg)
                    SEARCH: begin
                        if (vs_fall) begin
                            state_next = MEASURE;
                            good_next  = '0;
                        end
                    end
                    MEASURE: begin
                        if (vs_fall) begin
                            if (frame_ok) begin
                                good_next = good_cnt_reg + 3'd1;
                                if (good_cnt_reg + 3'd1 >= LOCK_N) state_next = LOCKED;
                            end else begin
                                good_next = '0;
                            end
                        end
                    end
                    LOCKED: begin
                        if (line_err || (vs_fall && !frame_ok)) begin
                            err_next   = 1'b1;
                            state_next = MEASURE;
                            good_next  = '0;
                        end
                    end
                    default: begin
                        state_next = SEARCH;
                        good_next  = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hs_s1_reg    <= 1'b1;
            vs_s1_reg    <= 1'b1;
            de_s1_reg    <= 1'b0;
            hs_s2_reg    <= 1'b1;
            vs_s2_reg    <= 1'b1;
            de_s2_reg    <= 1'b0;
            rgb_s1_reg   <= '0;
            en_d_reg     <= 1'b0;
            h_len_reg    <= '0;
            line_cnt_reg <= '0;
            x_reg        <= '0;
            y_reg        <= '0;
            line_bad_reg <= 1'b0;
            pix_valid    <= 1'b0;
            pix_data     <= '0;
            pix_x        <= '0;
            pix_y        <= '0;
            sof          <= 1'b0;
            eol          <= 1'b0;
            locked       <= 1'b0;
            err_fmt      <= 1'b0;
            line_len     <= '0;
            frame_lines  <= '0;
        end else begin
            hs_s1_reg  <= Hs;
            vs_s1_reg  <= Vs;
            de_s1_reg  <= D_En;
            rgb_s1_reg <= rgb_in;
            hs_s2_reg  <= hs_s1_reg;
            vs_s2_reg  <= vs_s1_reg;
            de_s2_reg  <= de_s1_reg;
            en_d_reg   <= en;
            locked     <= (state_reg == LOCKED);
            err_fmt    <= err_next;
            pix_valid  <= 1'b0;
            sof        <= 1'b0;
            eol        <= 1'b0;
            if (en) begin
                sof <= vs_fall;
                eol <= de_fall;
                if (hs_fall) begin
                    line_len  <= h_len_reg;
                    h_len_reg <= CNT_WIDTH'(1);
                end else if (h_len_reg != '1) begin
                    h_len_reg <= h_len_reg + 1'b1;
                end
                if (vs_fall) begin
                    frame_lines  <= line_cnt_reg;
                    line_cnt_reg <= hs_fall ? CNT_WIDTH'(1) : '0;
                end else if (hs_fall && line_cnt_reg != '1) begin
                    line_cnt_reg <= line_cnt_reg + 1'b1;
                end
                if (hs_fall)                        x_reg <= '0;
                else if (de_s1_reg && x_reg != '1)  x_reg <= x_reg + 1'b1;
                if (vs_fall)                        y_reg <= '0;
                else if (de_fall && y_reg != '1)    y_reg <= y_reg + 1'b1;
                if (vs_fall)                        line_bad_reg <= 1'b0;
                else if (de_fall && x_reg != H_ACT) line_bad_reg <= 1'b1;
                if (capture) begin
                    pix_valid <= 1'b1;
                    pix_data  <= rgb_s1_reg;
                    pix_x     <= x_reg;
                    pix_y     <= y_reg;
                end
            end
        end
    end

`ifdef RX_FRAME_CHECKSUM_EN
    logic [15:0] sum_acc_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_acc_reg <= '0;
            frame_sum   <= '0;
        end else if (sof) begin
            frame_sum   <= sum_acc_reg;
            sum_acc_reg <= pix_valid ? 16'(pix_data) : 16'd0;
        end else if (pix_valid) begin
            sum_acc_reg <= sum_acc_reg + 16'(pix_data);
        end
    end
`endif

endmodule

// File: tb/tb_vga_rx_capture.sv
// Bench for vga_rx_capture on a reduced raster (24 clk x 12 lines, 16x8 active) with random pixel data.
// Frame checksum is also checked when RX_FRAME_CHECKSUM_EN is defined.
module tb_vga_rx_capture;
    localparam int DW = 8, CW = 10, HA = 16, VA = 8, LF = 2;
    localparam int LINE = 24, HS_LOW = 4, DE_START = 6, NLINES = 12, VS_LINES = 2, ACT0 = 2;

    logic clk = 1'b0;
    always #20 clk = ~clk;

    logic rst = 1'b1, en = 1'b1, Hs = 1'b1, Vs = 1'b1, D_En = 1'b0;
    logic [DW-1:0] rgb_in = '0;
    logic pix_valid, sof, eol, locked, err_fmt;
    logic [DW-1:0] pix_data;
    logic [CW-1:0] pix_x, pix_y, line_len, frame_lines;
`ifdef RX_FRAME_CHECKSUM_EN
    logic [15:0] frame_sum;
`endif

    vga_rx_capture #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .H_ACTIVE(HA), .V_ACTIVE(VA),
                     .LOCK_FRAMES(LF)) dut (
        .clk(clk), .rst(rst), .en(en), .Hs(Hs), .Vs(Vs), .D_En(D_En), .rgb_in(rgb_in),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y),
        .sof(sof), .eol(eol), .locked(locked), .err_fmt(err_fmt),
        .line_len(line_len), .frame_lines(frame_lines)
`ifdef RX_FRAME_CHECKSUM_EN
        , .frame_sum(frame_sum)
`endif
    );

    typedef struct {int x; int y; int d; int c;} pix_t;
    pix_t exp_q[$];
    pix_t obs_q[$];
    pix_t mon_p;

    int cyc = 0;
    int n_cmp = 0, n_bad = 0;
    int sof_cnt = 0, eol_cnt = 0, err_cnt = 0, err_cyc = -1, lock_rise_cyc = -1;
    logic locked_prev = 1'b0;

    // reference model state: 0 searching, 1 measuring, 2 locked
    int m_state = 0, m_good = 0, m_y = 0, m_err_cyc = -2, m_lock_cyc = -2;
    bit m_ok = 1'b1;
    int m_sum = 0, m_prev_sum = 0;
    logic [52:0] rst_snap = '1;
    int en_lo_cyc = 0, en_hi_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (pix_valid) begin
            mon_p.x = int'(pix_x);
            mon_p.y = int'(pix_y);
            mon_p.d = int'(pix_data);
            mon_p.c = cyc;
            obs_q.push_back(mon_p);
        end
        if (sof) sof_cnt++;
        if (eol) eol_cnt++;
        if (err_fmt) begin
            err_cnt++;
            err_cyc = cyc;
        end
        if (locked && !locked_prev) lock_rise_cyc = cyc;
        locked_prev = locked;
    end

    task automatic model_vs_fall();
        bit good;
        good = m_ok && (m_y == VA);
        if (m_state == 0) begin
            m_state = 1;
            m_good  = 0;
        end else if (m_state == 1) begin
            if (good) begin
                m_good++;
                if (m_good == LF) begin
                    m_state    = 2;
                    m_lock_cyc = cyc + 3;
                end
            end else begin
                m_good = 0;
            end
        end else if (!good) begin
            m_state   = 1;
            m_good    = 0;
            m_err_cyc = cyc + 2;
        end
        m_ok       = 1'b1;
        m_y        = 0;
        m_prev_sum = m_sum;
        m_sum      = 0;
    endtask

    // One raster frame; Vs falls together with Hs at the first clk of line 0.
    task automatic gen_frame(input int long_line, input int rst_line, input int en_off_line);
        int npix;
        pix_t p;
        for (int ln = 0; ln < NLINES; ln++) begin
            npix = (ln == long_line) ? HA + 1 : HA;
            for (int c = 0; c < LINE; c++) begin
                @(negedge clk);
                if (ln == 0 && c == 0) model_vs_fall();
                if (ln == rst_line && c == 5) begin
                    rst_snap = {pix_valid, pix_data, pix_x, pix_y, sof, eol, locked, err_fmt,
                                line_len, frame_lines};
                    rst = 1'b0;
                end
                if (ln == rst_line && c == 4) begin
                    rst = 1'b1;
                    m_state = 0;
                    m_good  = 0;
                    m_sum   = 0;
                end
                if (en_off_line >= 0 && ln == en_off_line && c == 0) begin
                    en = 1'b0;
                    en_lo_cyc = cyc;
                    m_state = 0;
                    m_good  = 0;
                end
                if (en_off_line >= 0 && ln == en_off_line + 2 && c == 0) begin
                    en = 1'b1;
                    en_hi_cyc = cyc;
                end
                Hs     = (c >= HS_LOW);
                Vs     = (ln >= VS_LINES);
                D_En   = (ln >= ACT0 && ln < ACT0 + VA && c >= DE_START && c < DE_START + npix);
                rgb_in = 8'($urandom_range(0, 255));
                if (D_En && m_state == 2 && (c - DE_START) < HA) begin
                    p.x = c - DE_START;
                    p.y = ln - ACT0;
                    p.d = int'(rgb_in);
                    p.c = cyc;
                    exp_q.push_back(p);
                    m_sum += int'(rgb_in);
                end
                if (ln >= ACT0 && ln < ACT0 + VA && c == DE_START + npix) begin
                    if (npix != HA) begin
                        m_ok = 1'b0;
                        if (m_state == 2) begin
                            m_state   = 1;
                            m_good    = 0;
                            m_err_cyc = cyc + 2;
                        end
                    end
                    m_y++;
                end
            end
        end
    endtask

    task automatic test_reset();
        int s0, e0;
        rst = 1'b1; en = 1'b1; Hs = 1'b1; Vs = 1'b1; D_En = 1'b0;
        repeat (4) @(negedge clk);
        n_cmp++;
        if ({pix_valid, pix_data, pix_x, pix_y, sof, eol, locked, err_fmt, line_len, frame_lines} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got valid=%b x=%0d y=%0d sof=%b eol=%b locked=%b err=%b len=%0d lines=%0d, want all 0",
                     pix_valid, pix_x, pix_y, sof, eol, locked, err_fmt, line_len, frame_lines);
        end
        rst = 1'b0;
        s0 = sof_cnt; e0 = eol_cnt;
        repeat (4) @(negedge clk);
        n_cmp++;
        if (sof_cnt != s0 || eol_cnt != e0 || err_cnt != 0) begin
            n_bad++;
            $display("FAIL reset_no_false_edge: got sof=%0d eol=%0d err=%0d, want 0 0 0",
                     sof_cnt - s0, eol_cnt - e0, err_cnt);
        end
        m_state = 0; m_good = 0; m_sum = 0;
        exp_q.delete(); obs_q.delete();
        $display("test_reset done");
    endtask

    task automatic test_lock();
        int e0;
        e0 = err_cnt;
        repeat (4) gen_frame(-1, -1, -1);
        n_cmp++;
        if (locked !== 1'b1) begin
            n_bad++; $display("FAIL lock_state: got %b, want 1", locked);
        end
        n_cmp++;
        if (lock_rise_cyc != m_lock_cyc) begin
            n_bad++; $display("FAIL lock_time: got cycle %0d, want %0d", lock_rise_cyc, m_lock_cyc);
        end
        n_cmp++;
        if (line_len !== CW'(LINE)) begin
            n_bad++; $display("FAIL line_len: got %0d, want %0d", line_len, LINE);
        end
        n_cmp++;
        if (frame_lines !== CW'(NLINES)) begin
            n_bad++; $display("FAIL frame_lines: got %0d, want %0d", frame_lines, NLINES);
        end
        n_cmp++;
        if (err_cnt != e0) begin
            n_bad++; $display("FAIL lock_no_err: got %0d pulses, want 0", err_cnt - e0);
        end
        n_cmp++;
        if (obs_q.size() != exp_q.size() || obs_q.size() != 2 * HA * VA) begin
            n_bad++; $display("FAIL lock_pix_count: got %0d, want %0d", obs_q.size(), exp_q.size());
        end
        exp_q.delete(); obs_q.delete();
        $display("test_lock done: line_len=%0d frame_lines=%0d", line_len, frame_lines);
    endtask

    task automatic test_pixels();
        int s0, e0;
        s0 = sof_cnt; e0 = eol_cnt;
        exp_q.delete(); obs_q.delete();
        repeat (2) gen_frame(-1, -1, -1);
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_bad++; $display("FAIL pix_count: got %0d, want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i].x != exp_q[i].x || obs_q[i].y != exp_q[i].y ||
                obs_q[i].d != exp_q[i].d || obs_q[i].c != exp_q[i].c + 2) begin
                n_bad++;
                $display("FAIL pixel[%0d]: got x=%0d y=%0d d=%0h cyc=%0d, want x=%0d y=%0d d=%0h cyc=%0d",
                         i, obs_q[i].x, obs_q[i].y, obs_q[i].d, obs_q[i].c,
                         exp_q[i].x, exp_q[i].y, exp_q[i].d, exp_q[i].c + 2);
            end
        end
        n_cmp++;
        if (sof_cnt - s0 != 2) begin
            n_bad++; $display("FAIL sof_count: got %0d, want 2", sof_cnt - s0);
        end
        n_cmp++;
        if (eol_cnt - e0 != 2 * VA) begin
            n_bad++; $display("FAIL eol_count: got %0d, want %0d", eol_cnt - e0, 2 * VA);
        end
`ifdef RX_FRAME_CHECKSUM_EN
        n_cmp++;
        if (frame_sum !== 16'(m_prev_sum)) begin
            n_bad++; $display("FAIL frame_sum: got %04h, want %04h", frame_sum, 16'(m_prev_sum));
        end
`endif
        exp_q.delete(); obs_q.delete();
        $display("test_pixels done: %0d pixels", 2 * HA * VA);
    endtask

    task automatic test_long_line();
        int e0;
        e0 = err_cnt;
        exp_q.delete(); obs_q.delete();
        gen_frame(5, -1, -1);
        n_cmp++;
        if (err_cnt - e0 != 1) begin
            n_bad++; $display("FAIL long_err_count: got %0d, want 1", err_cnt - e0);
        end
        n_cmp++;
        if (err_cyc != m_err_cyc) begin
            n_bad++; $display("FAIL long_err_time: got cycle %0d, want %0d", err_cyc, m_err_cyc);
        end
        n_cmp++;
        if (locked !== 1'b0) begin
            n_bad++; $display("FAIL long_unlock: got %b, want 0", locked);
        end
        n_cmp++;
        if (obs_q.size() != exp_q.size() || obs_q.size() != 4 * HA) begin
            n_bad++; $display("FAIL long_pix_count: got %0d, want %0d", obs_q.size(), exp_q.size());
        end
        repeat (2) gen_frame(-1, -1, -1);
        n_cmp++;
        if (locked !== 1'b0) begin
            n_bad++; $display("FAIL long_early_lock: got %b, want 0", locked);
        end
        gen_frame(-1, -1, -1);
        n_cmp++;
        if (locked !== 1'b1 || lock_rise_cyc != m_lock_cyc) begin
            n_bad++; $display("FAIL long_relock: got locked=%b at %0d, want 1 at %0d",
                              locked, lock_rise_cyc, m_lock_cyc);
        end
        n_cmp++;
        if (err_cnt - e0 != 1) begin
            n_bad++; $display("FAIL long_err_total: got %0d, want 1", err_cnt - e0);
        end
        exp_q.delete(); obs_q.delete();
        $display("test_long_line done");
    endtask

    task automatic test_mid_reset();
        exp_q.delete(); obs_q.delete();
        gen_frame(-1, 5, -1);
        n_cmp++;
        if (rst_snap !== '0) begin
            n_bad++; $display("FAIL midrst_outputs: got %h, want 0", rst_snap);
        end
        n_cmp++;
        if (obs_q.size() != exp_q.size() || locked !== 1'b0) begin
            n_bad++; $display("FAIL midrst_pix: got %0d pixels locked=%b, want %0d pixels locked=0",
                              obs_q.size(), locked, exp_q.size());
        end
        repeat (2) gen_frame(-1, -1, -1);
        n_cmp++;
        if (locked !== 1'b0) begin
            n_bad++; $display("FAIL midrst_early_lock: got %b, want 0", locked);
        end
        gen_frame(-1, -1, -1);
        n_cmp++;
        if (locked !== 1'b1 || lock_rise_cyc != m_lock_cyc) begin
            n_bad++; $display("FAIL midrst_relock: got locked=%b at %0d, want 1 at %0d",
                              locked, lock_rise_cyc, m_lock_cyc);
        end
        exp_q.delete(); obs_q.delete();
        $display("test_mid_reset done");
    endtask

    task automatic test_enable();
        int in_win;
        exp_q.delete(); obs_q.delete();
        gen_frame(-1, -1, 3);
        in_win = 0;
        foreach (obs_q[i])
            if (obs_q[i].c >= en_lo_cyc + 2 && obs_q[i].c <= en_hi_cyc + 1) in_win++;
        n_cmp++;
        if (in_win != 0) begin
            n_bad++; $display("FAIL en_low_pixels: got %0d, want 0", in_win);
        end
        n_cmp++;
        if (obs_q.size() != exp_q.size() || locked !== 1'b0) begin
            n_bad++; $display("FAIL en_resync: got %0d pixels locked=%b, want %0d pixels locked=0",
                              obs_q.size(), locked, exp_q.size());
        end
        repeat (2) gen_frame(-1, -1, -1);
        n_cmp++;
        if (locked !== 1'b0) begin
            n_bad++; $display("FAIL en_early_lock: got %b, want 0", locked);
        end
        gen_frame(-1, -1, -1);
        n_cmp++;
        if (locked !== 1'b1 || lock_rise_cyc != m_lock_cyc) begin
            n_bad++; $display("FAIL en_relock: got locked=%b at %0d, want 1 at %0d",
                              locked, lock_rise_cyc, m_lock_cyc);
        end
        exp_q.delete(); obs_q.delete();
        $display("test_enable done");
    endtask

    initial begin
        test_reset();
        test_lock();
        test_pixels();
        test_long_line();
        test_mid_reset();
        test_enable();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
